routing_dir_pe_param: RTL and testbench

- Parametrised next-generation route-compute stage for the PE injection port of a mesh router.
- Pops packets from the PE's first-word-fall-through (FWFT) input FIFO into a small internal buffer.
- Computes dimension-ordered routing (XY or YX) on the head packet, decrements the consumed hop field, and forwards to E/W/S/N, or ejects to Local when both hop counts are zero.
- Full throughput (one packet per cycle) with no bubble between packets, and a saturating head-of-line stall monitor.

---
 rtl/noc_pkg.sv | 25 ++
 rtl/noc_pkt_buf.sv | 57 +++++
 rtl/routing_dir_pe_param.sv | 136 +++++++++++++
 tb/tb_routing_dir_pe_param.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port indices,
// default packet field positions and route order.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  localparam logic [2:0] PORT_E = 3'd0;
  localparam logic [2:0] PORT_W = 3'd1;
  localparam logic [2:0] PORT_S = 3'd2;
  localparam logic [2:0] PORT_N = 3'd3;
  localparam logic [2:0] PORT_L = 3'd4;

  localparam int PKT_W_D    = 64;
  localparam int HOP_W_D    = 2;
  localparam int DIRX_BIT_D = 58;
  localparam int DIRY_BIT_D = 57;
  localparam int HOPX_LSB_D = 55;
  localparam int HOPY_LSB_D = 53;

  typedef enum logic {
    ROUTE_XY = 1'b0,
    ROUTE_YX = 1'b1
  } route_order_e;

endpackage

// File: rtl/noc_pkt_buf.sv
// Small shifting packet FIFO, head at entry 0,
// with simultaneous push/pop.
module noc_pkt_buf #(
  parameter  int DEPTH = 2,
  parameter  int W     = 64,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  r_mem   [DEPTH];
  logic [W-1:0]  w_shift [DEPTH];
  logic [W-1:0]  w_nxt   [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_wr_idx;

  for (genvar i = 0; i < DEPTH; i++) begin : g_sh
    if (i < DEPTH - 1) begin : g_mid
      assign w_shift[i] = pop ? r_mem[i+1] : r_mem[i];
    end else begin : g_last
      assign w_shift[i] = r_mem[i];
    end
  end

  // A pop shifts everything down, so the write slot moves too.
  assign w_wr_idx = pop ? r_count - CW'(1) : r_count;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = (push && w_wr_idx == CW'(i)) ? din : w_shift[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      r_mem[i] <= w_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  assign head  = r_mem[0];
  assign count = r_count;

endmodule

// File: rtl/routing_dir_pe_param.sv
// PE-injection route-compute stage: buffers FWFT input,
// applies XY/YX routing, tracks head-of-line stalls.
module routing_dir_pe_param
  import noc_pkg::*;
#(
  parameter int PKT_W        = PKT_W_D,
  parameter int HOP_W        = HOP_W_D,
  parameter int DIRX_BIT     = DIRX_BIT_D,
  parameter int DIRY_BIT     = DIRY_BIT_D,
  parameter int HOPX_LSB     = HOPX_LSB_D,
  parameter int HOPY_LSB     = HOPY_LSB_D,
  parameter int BUF_DEPTH    = 2,
  parameter int ROUTE_YX     = 0,
  parameter int STALL_W      = 8,
  parameter int STALL_THRESH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           empty,
  input  logic [PKT_W-1:0]               in_packet,
  output logic                           read_en,
  input  logic [NUM_PORTS-1:0]           full,
  output logic [NUM_PORTS*PKT_W-1:0]     out_packet,
  output logic [NUM_PORTS-1:0]           out_req,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count,
  output logic [STALL_W-1:0]             stall_cnt,
  output logic                           stall_alert
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam route_order_e ORDER =
    (ROUTE_YX != 0) ? route_order_e'(1'b1) : ROUTE_XY;

  logic [PKT_W-1:0]     w_head;
  logic [PKT_W-1:0]     w_pkt;
  logic [CW-1:0]        w_count;
  logic                 w_valid;
  logic                 w_use_x;
  logic                 w_use_y;
  logic                 w_fire;
  logic                 w_blocked;
  logic [2:0]           w_tgt;
  logic [NUM_PORTS-1:0] w_req;
  logic [HOP_W-1:0]     w_hx;
  logic [HOP_W-1:0]     w_hy;
  logic [STALL_W-1:0]   r_stall;
  logic [STALL_W-1:0]   w_stall_nxt;
  logic                 r_alert;

  noc_pkt_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (PKT_W)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (read_en),
    .din   (in_packet),
    .pop   (w_fire),
    .head  (w_head),
    .count (w_count)
  );

  assign w_valid = (w_count != '0);
  assign w_hx    = w_head[HOPX_LSB +: HOP_W];
  assign w_hy    = w_head[HOPY_LSB +: HOP_W];

  always_comb begin
    w_use_x = 1'b0;
    w_use_y = 1'b0;
    if (ORDER == ROUTE_XY) begin
      w_use_x = (w_hx != '0);
      w_use_y = (w_hx == '0) && (w_hy != '0);
    end else begin
      w_use_y = (w_hy != '0);
      w_use_x = (w_hy == '0) && (w_hx != '0);
    end
  end

  // Consumed hop field is nonzero, so the decrement never wraps.
  always_comb begin
    w_tgt = PORT_L;
    w_pkt = w_head;
    unique case (1'b1)
      w_use_x: begin
        w_tgt = w_head[DIRX_BIT] ? PORT_W : PORT_E;
        w_pkt[HOPX_LSB +: HOP_W] = w_hx - HOP_W'(1);
      end
      w_use_y: begin
        w_tgt = w_head[DIRY_BIT] ? PORT_S : PORT_N;
        w_pkt[HOPY_LSB +: HOP_W] = w_hy - HOP_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_req[i] = !reset && w_valid && (w_tgt == 3'(i)) && !full[i];
    end
  end

  assign w_fire    = |w_req;
  assign w_blocked = w_valid && full[w_tgt];

  // Pop-through: a firing head frees a slot in the same cycle.
  assign read_en = !reset && !empty &&
                   ((w_count < CW'(BUF_DEPTH)) || w_fire);

  always_comb begin
    w_stall_nxt = '0;
    if (w_blocked) begin
      w_stall_nxt = (&r_stall) ? r_stall : r_stall + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
      r_alert <= 1'b0;
    end else begin
      r_stall <= w_stall_nxt;
      r_alert <= (32'(w_stall_nxt) >= STALL_THRESH);
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_out
    assign out_packet[g*PKT_W +: PKT_W] = w_valid ? w_pkt : '0;
  end

  assign out_req     = w_req;
  assign buf_count   = w_count;
  assign stall_cnt   = r_stall;
  assign stall_alert = r_alert;

endmodule

// File: tb/tb_routing_dir_pe_param.sv
// Random + directed bench for routing_dir_pe_param,
// two configurations against a queue-level reference model.
module tb_routing_dir_pe_param;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         empty;
  logic [63:0]  in_packet;
  logic [4:0]   full;

  logic         re_a, re_b;
  logic [4:0]   req_a, req_b;
  logic [319:0] opk_a, opk_b;
  logic [1:0]   bc_a;
  logic [0:0]   bc_b;
  logic [7:0]   sc_a;
  logic [3:0]   sc_b;
  logic         sa_a, sa_b;

  routing_dir_pe_param u_dut_a (
    .clk         (clk),
    .reset       (reset),
    .empty       (empty),
    .in_packet   (in_packet),
    .read_en     (re_a),
    .full        (full),
    .out_packet  (opk_a),
    .out_req     (req_a),
    .buf_count   (bc_a),
    .stall_cnt   (sc_a),
    .stall_alert (sa_a)
  );

  routing_dir_pe_param #(
    .BUF_DEPTH    (1),
    .ROUTE_YX     (1),
    .STALL_W      (4),
    .STALL_THRESH (8)
  ) u_dut_b (
    .clk         (clk),
    .reset       (reset),
    .empty       (empty),
    .in_packet   (in_packet),
    .read_en     (re_b),
    .full        (full),
    .out_packet  (opk_b),
    .out_req     (req_b),
    .buf_count   (bc_b),
    .stall_cnt   (sc_b),
    .stall_alert (sa_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int DEP  [2] = '{2, 1};
  bit YX   [2] = '{1'b0, 1'b1};
  int SMAX [2] = '{255, 15};
  int THR  [2] = '{16, 8};

  logic [63:0] mbuf [2][4];
  int          mcnt [2];
  int          mstall [2];
  bit          malert [2];

  task automatic chk(input string tag, input logic [319:0] act,
                     input logic [319:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Port index for packet p; o receives the forwarded packet.
  function automatic int route(input logic [63:0] p, input bit yx,
                               output logic [63:0] o);
    logic [1:0] hx;
    logic [1:0] hy;
    hx = p[56:55];
    hy = p[54:53];
    o  = p;
    if (!yx) begin
      if (hx != 0) begin o = p - (64'd1 << 55); return p[58] ? 1 : 0; end
      if (hy != 0) begin o = p - (64'd1 << 53); return p[57] ? 2 : 3; end
    end else begin
      if (hy != 0) begin o = p - (64'd1 << 53); return p[57] ? 2 : 3; end
      if (hx != 0) begin o = p - (64'd1 << 55); return p[58] ? 1 : 0; end
    end
    return 4;
  endfunction

  task automatic expect_k(input int k, output logic re,
                          output logic [4:0] rq, output logic [319:0] op,
                          output bit fire, output bit blk);
    logic [63:0] o;
    int          port;
    bit          v;
    v    = mcnt[k] > 0;
    port = route(mbuf[k][0], YX[k], o);
    fire = v && !reset && !full[port];
    blk  = v && full[port];
    rq   = fire ? 5'(1 << port) : 5'd0;
    op   = v ? {5{o}} : '0;
    re   = !reset && !empty && ((mcnt[k] < DEP[k]) || fire);
  endtask

  task automatic check_inst(input int k, input logic re,
                            input logic [4:0] rq, input logic [319:0] op,
                            input logic [2:0] bc, input logic [7:0] sc,
                            input logic sa);
    logic         ere;
    logic [4:0]   erq;
    logic [319:0] eop;
    bit           f, b;
    string        nm;
    nm = (k == 0) ? "A" : "B";
    expect_k(k, ere, erq, eop, f, b);
    chk({nm, ".read_en"}, 320'(re), 320'(ere));
    chk({nm, ".out_req"}, 320'(rq), 320'(erq));
    chk({nm, ".out_packet"}, op, eop);
    chk({nm, ".buf_count"}, 320'(bc), 320'(mcnt[k]));
    chk({nm, ".stall_cnt"}, 320'(sc), 320'(mstall[k]));
    chk({nm, ".stall_alert"}, 320'(sa), 320'(malert[k]));
  endtask

  task automatic drive(input bit rst, input bit emp,
                       input logic [63:0] pk, input logic [4:0] fl);
    @(negedge clk);
    reset     = rst;
    empty     = emp;
    in_packet = pk;
    full      = fl;
    #1;
    check_inst(0, re_a, req_a, opk_a, {1'b0, bc_a}, sc_a, sa_a);
    check_inst(1, re_b, req_b, opk_b, {2'b0, bc_b}, {4'b0, sc_b}, sa_b);
  endtask

  task automatic commit();
    logic         re;
    logic [4:0]   rq;
    logic [319:0] op;
    bit           f, b;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      expect_k(k, re, rq, op, f, b);
      if (reset) begin
        mcnt[k]   = 0;
        mstall[k] = 0;
        malert[k] = 1'b0;
      end else begin
        if (f) begin
          for (int j = 0; j < 3; j++) mbuf[k][j] = mbuf[k][j+1];
          mcnt[k]--;
        end
        if (re) begin
          mbuf[k][mcnt[k]] = in_packet;
          mcnt[k]++;
        end
        mstall[k] = b ? ((mstall[k] == SMAX[k]) ? SMAX[k] : mstall[k] + 1) : 0;
        malert[k] = mstall[k] >= THR[k];
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit emp,
                     input logic [63:0] pk, input logic [4:0] fl);
    drive(rst, emp, pk, fl);
    commit();
  endtask

  function automatic logic [63:0] mk(input bit dx, input bit dy,
                                     input logic [1:0] hx,
                                     input logic [1:0] hy);
    logic [63:0] p;
    p        = {$urandom, $urandom};
    p[58]    = dx;
    p[57]    = dy;
    p[56:55] = hx;
    p[54:53] = hy;
    return p;
  endfunction

  initial begin
    logic [63:0] p, e;
    int          nre, nrq;
    logic [4:0]  fl;
    reset     = 1'b1;
    empty     = 1'b1;
    in_packet = '0;
    full      = '0;
    for (int k = 0; k < 2; k++) begin
      mcnt[k]   = 0;
      mstall[k] = 0;
      malert[k] = 1'b0;
      for (int j = 0; j < 4; j++) mbuf[k][j] = '0;
    end
    repeat (2) @(posedge clk);
    cyc(1'b1, 1'b1, '0, '0);

    p = mk(1'b0, 1'b1, 2'd2, 2'd1);
    drive(1'b0, 1'b0, p, 5'b0);
    chk("xy.read_en", 320'(re_a), 320'(1));
    commit();
    drive(1'b0, 1'b1, '0, 5'b0);
    e = p;
    e[56:55] = 2'd1;
    chk("xy.out_req", 320'(req_a), 320'(5'b00001));
    chk("xy.pkt_e", 320'(opk_a[63:0]), 320'(e));
    commit();

    p = mk(1'b1, 1'b0, 2'd0, 2'd0);
    cyc(1'b0, 1'b0, p, 5'b0);
    drive(1'b0, 1'b1, '0, 5'b0);
    chk("loc.out_req", 320'(req_a), 320'(5'b10000));
    chk("loc.pkt_l", 320'(opk_a[319:256]), 320'(p));
    commit();

    p = mk(1'b0, 1'b0, 2'd1, 2'd2);
    cyc(1'b0, 1'b0, p, 5'b0);
    drive(1'b0, 1'b1, '0, 5'b0);
    e = p;
    e[54:53] = 2'd1;
    chk("yx.out_req", 320'(req_b), 320'(5'b01000));
    chk("yx.pkt_n", 320'(opk_b[255:192]), 320'(e));
    commit();

    nre = 0;
    nrq = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, (i == 8), {$urandom, $urandom}, 5'b0);
      if (re_b) nre++;
      if (req_b != 0) nrq++;
      commit();
    end
    chk("b2b.read_en", 320'(nre), 320'(8));
    chk("b2b.out_req", 320'(nrq), 320'(8));

    cyc(1'b1, 1'b1, '0, '0);
    for (int i = 0; i < 31; i++) begin
      cyc(1'b0, 1'b0, mk(1'b1, 1'($urandom), 2'($urandom_range(1, 3)), 2'd0),
          5'b00010);
    end
    drive(1'b0, 1'b0, mk(1'b1, 1'b0, 2'd1, 2'd0), 5'b00000);
    chk("stall.cnt", 320'(sc_a), 320'(30));
    chk("stall.sat", 320'(sc_b), 320'(15));
    chk("stall.alert", 320'(sa_a), 320'(1));
    chk("stall.bufcnt", 320'(bc_a), 320'(2));
    chk("rel.out_req", 320'(req_a), 320'(5'b00010));
    chk("rel.read_en", 320'(re_a), 320'(1));
    commit();
    drive(1'b0, 1'b0, mk(1'b1, 1'b0, 2'd1, 2'd0), 5'b00010);
    chk("rel.clear", 320'(sc_a), 320'(0));
    commit();
    repeat (3) cyc(1'b0, 1'b0, mk(1'b1, 1'b0, 2'd1, 2'd0), 5'b00010);

    drive(1'b1, 1'b0, mk(1'b1, 1'b0, 2'd1, 2'd0), 5'b00000);
    chk("rst.read_en", 320'(re_a), 320'(0));
    chk("rst.out_req", 320'(req_a), 320'(0));
    commit();
    drive(1'b0, 1'b1, '0, 5'b00000);
    chk("rst.bufcnt", 320'(bc_a), 320'(0));
    chk("rst.stall", 320'(sc_a), 320'(0));
    chk("rst.out_req", 320'(req_a), 320'(0));
    commit();

    for (int i = 0; i < 3000; i++) begin
      if (((i / 200) % 2) == 0) fl = 5'($urandom & $urandom & $urandom);
      else                      fl = 5'($urandom);
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
          {$urandom, $urandom}, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
